// File: rtl/pccu_pc_ctrl.sv
// Program counter control: holds the fetch PC, steps by PC_INC or loads a branch target; one-cycle latency.
// Optional PCCU_BRANCH_ALIGN_EN clears bit 0 of branch targets and adds a registered misaligned flag.
module pccu_pc_ctrl #(
  parameter int                     PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter int                     PC_INC       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                selPCsrc,
  input  logic [PC_WIDTH-1:0] branchIn,
  output logic [PC_WIDTH-1:0] PC,
`ifdef PCCU_BRANCH_ALIGN_EN
  output logic                misaligned,
`endif
  output logic                valid
);

  localparam logic [PC_WIDTH-1:0] LP_INC = PC_WIDTH'(PC_INC);

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_valid;
  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_next_pc;

`ifdef PCCU_BRANCH_ALIGN_EN
  // JALR semantics: the low bit of a jump target is always discarded
  assign w_target = {branchIn[PC_WIDTH-1:1], 1'b0};
`else
  assign w_target = branchIn;
`endif

  always_comb begin
    w_next_pc = r_pc + LP_INC;
    if (selPCsrc) begin
      w_next_pc = w_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
    end else if (go) begin
      r_pc    <= w_next_pc;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef PCCU_BRANCH_ALIGN_EN
  logic r_misaligned;

  // Flag only tracks the most recent update; a hold keeps the last value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else if (go) begin
      r_misaligned <= selPCsrc & branchIn[1];
    end
  end

  assign misaligned = r_misaligned;
`endif

  assign PC    = r_pc;
  assign valid = r_valid;

endmodule

// File: tb/tb_pccu_pc_ctrl.sv
// Self-checking bench for pccu_pc_ctrl: directed plan items plus random traffic against a behavioural model.
module tb_pccu_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        selPCsrc;
  logic [31:0] branchIn;
  logic [31:0] PC;
  logic        valid;
`ifdef PCCU_BRANCH_ALIGN_EN
  logic        misaligned;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic        m_vld;
  logic        m_mis;

  pccu_pc_ctrl #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .PC_INC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .selPCsrc   (selPCsrc),
    .branchIn   (branchIn),
    .PC         (PC),
`ifdef PCCU_BRANCH_ALIGN_EN
    .misaligned (misaligned),
`endif
    .valid      (valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, compare just after the edge
  task automatic cyc(input logic r, input logic g, input logic s, input logic [31:0] b);
    rst_n    = r;
    go       = g;
    selPCsrc = s;
    branchIn = b;
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_vld = 1'b0; m_mis = 1'b0;
    end else if (!g) begin
      m_vld = 1'b0;
    end else if (s) begin
`ifdef PCCU_BRANCH_ALIGN_EN
      m_pc  = b & ~32'h1;
      m_mis = b[1];
`else
      m_pc  = b;
`endif
      m_vld = 1'b1;
    end else begin
      m_pc  = m_pc + 32'd4;
      m_vld = 1'b1;
      m_mis = 1'b0;
    end
    #1;
    check_eq("pc", PC, m_pc);
    check_eq("valid", valid, m_vld);
`ifdef PCCU_BRANCH_ALIGN_EN
    check_eq("misaligned", misaligned, m_mis);
`endif
  endtask

  initial begin
    m_pc = 32'h0; m_vld = 1'b0; m_mis = 1'b0;
    rst_n = 1'b0; go = 1'b0; selPCsrc = 1'b0; branchIn = 32'h0;

    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, $urandom);
    check_eq("reset_pc", PC, 32'h0);
    check_eq("reset_valid", valid, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, $urandom_range(0, 1), $urandom);
    check_eq("idle_pc", PC, 32'h0);

    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0, $urandom);
    check_eq("seq100", PC, 32'd400);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("seq101", PC, 32'd404);
    check_eq("seq_valid", valid, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 32'hdeadbeef);
`ifdef PCCU_BRANCH_ALIGN_EN
    check_eq("branch", PC, 32'hdeadbeee);
    check_eq("branch_mis", misaligned, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("branch_step", PC, 32'hdeadbef2);
`else
    check_eq("branch", PC, 32'hdeadbeef);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("branch_step", PC, 32'hdeadbef3);
`endif

    cyc(1'b1, 1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 32'h5000);
      check_eq("freeze_pc", PC, 32'h100);
      check_eq("freeze_valid", valid, 1'b0);
    end

    cyc(1'b1, 1'b1, 1'b1, 32'hfffffffc);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("wrap", PC, 32'h0);

    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h1234);
    check_eq("midreset_pc", PC, 32'h0);
    check_eq("midreset_valid", valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("resume4", PC, 32'h4);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("resume8", PC, 32'h8);

    // Random mix: mostly running, some branches and holds, rare resets
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pccu_pc_ctrl.md
Name: pccu_pc_ctrl

Overview:
- Program Counter Control Unit for the RISC-V core fetch stage.
- Holds the architectural PC register.
- On each enabled clock, advances PC by one instruction (+4) or loads a branch/jump target selected by execute-stage control.
- Emits a valid strobe telling fetch that PC was updated on the last edge.

Parameters:
- PC_WIDTH, 32, width of PC and branch target.
- RESET_VECTOR, 0, PC value loaded by reset.
- PC_INC, 4, byte increment per sequential step.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- go  input  1  run enable; PC frozen while low.
- selPCsrc  input  1  PC source select: 0 = sequential (PC+PC_INC), 1 = branchIn.
- branchIn  input  PC_WIDTH  branch/jump target address.
- PC  output  PC_WIDTH  current program counter (registered).
- valid  output  1  high for the cycle after an edge on which PC was updated.

Interface note: one clock; reset is synchronous and active-low (clk, rst_n).

Behaviour:
- Reset:
  - rst_n sampled only on rising clk edges.
  - rst_n=0 at an edge → PC=RESET_VECTOR, valid=0.
  - Reset has priority over go and selPCsrc, including mid-run; a reset pulse in the middle of a branch discards the branch.
- Hold: rst_n=1, go=0 → PC holds its value; valid=0; selPCsrc and branchIn are ignored.
- Sequential step: rst_n=1, go=1, selPCsrc=0 → PC <= PC + PC_INC; valid=1 next cycle.
- Branch: rst_n=1, go=1, selPCsrc=1 → PC <= branchIn (full width, no masking unless the optional feature is enabled); valid=1 next cycle.
- Latency:
  - One cycle; the new PC is visible immediately after the edge.
  - N edges with go=1 and selPCsrc=0 from PC=0 give PC=4·N.
- Arithmetic:
  - Unsigned, modulo 2^PC_WIDTH.
  - PC=2^PC_WIDTH−4 steps to 0 with no flag.
  - A misaligned branch target (e.g. ...ef) is accepted as-is; subsequent steps add PC_INC to that value.
- Outputs driven directly from flops; no combinational path from inputs to PC or valid.
- go dropping: the PC freezes at the last value, and valid falls after the next edge.
- Back-to-back branches: each edge with selPCsrc=1 loads the current branchIn.

Optional Feature:
- Macro: PCCU_BRANCH_ALIGN_EN.
- Defined:
  - Branch load clears bit 0 of branchIn (RISC-V JALR target semantics).
  - Adds output port misaligned (1 bit, registered): set when the loaded target has bit 1 set, cleared on any other update or reset.
- Undefined:
  - branchIn loaded verbatim.
  - No misaligned port.

Test Plan:
- Reset and idle: rst_n=0 for 10 cycles, then 1 with go=0 for 100 cycles → PC=0, valid=0 throughout.
- Sequential run: go=1, selPCsrc=0 for exactly 100 rising edges from PC=0 → PC=400; one more edge → PC=404; valid=1.
- Branch: at PC=404, selPCsrc=1, branchIn=32'hdeadbeef, one edge → PC=32'hdeadbeef; selPCsrc=0, one edge → PC=32'hdeadbef3.
- Freeze: go=0 at PC=0x100 for 20 edges with selPCsrc=1, branchIn=0x5000 → PC stays 0x100; valid=0 after the first edge.
- Wrap: branch to 32'hfffffffc, then one step → PC=0.
- Reset mid-run: rst_n=0 for one edge while go=1, selPCsrc=1, branchIn=0x1234 → PC=RESET_VECTOR (0), valid=0; then run resumes 0,4,8. With PCCU_BRANCH_ALIGN_EN, branching to 0xdeadbeef → PC=0xdeadbeee, misaligned=1.
